// File: rtl/iter_shifter.sv
// Multi-cycle shifter: SLL, SRL, SRA and ROR, at most STEP bits per clock.
// Valid/ready handshake on both sides, one operation in flight, synchronous kill.
module iter_shifter #(
    parameter  int XLEN = 32,
    parameter  int STEP = 4,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_type,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROR} op_t;

    // One extra bit so that STEP == XLEN and XLEN itself are representable.
    localparam logic [SHW:0]    STEP_W = (SHW+1)'(STEP);
    localparam logic [SHW:0]    XLEN_W = (SHW+1)'(XLEN);
    localparam logic [XLEN-1:0] ONES   = '1;

    state_t          state_q, state_d;
    op_t             op_q, op_d;
    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  rem_q, rem_d;
    logic            sign_q, sign_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [SHW:0]    step_amt;
    logic [XLEN-1:0] shr;
    logic [XLEN-1:0] fill_mask;
    logic [XLEN-1:0] stepped;

    // One partial shift of the work register by min(remaining, STEP).
    always_comb begin
        step_amt  = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
        shr       = work_q >> step_amt;
        fill_mask = ~(ONES >> step_amt);
        case (op_q)
            OP_SLL:  stepped = work_q << step_amt;
            OP_SRL:  stepped = shr;
            OP_SRA:  stepped = shr | (sign_q ? fill_mask : '0);
            default: stepped = shr | (work_q << (XLEN_W - step_amt));
        endcase
    end

    assign in_ready = (state_q == S_IDLE) && !kill;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        sign_d  = sign_q;

        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d    = op_t'(in_type);
                        work_d  = in_data;
                        sign_d  = in_data[XLEN-1];
                        rem_d   = in_shamt;
                        state_d = (in_shamt == '0) ? S_DONE : S_BUSY;
                    end
                end
                S_BUSY: begin
                    work_d = stepped;
                    rem_d  = rem_q - step_amt[SHW-1:0];
                    if (rem_d == '0) state_d = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_SLL;
            work_q      <= '0;
            rem_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q     <= state_d;
            op_q        <= op_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = work_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (STEP=1,4,32) share stimulus; a per-instance
// one-shot-shift model with a latency countdown is compared every cycle, plus literal cases.
module tb_iter_shifter;

    localparam int N = 3;
    localparam int STEPS [N] = '{1, 4, 32};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_type = 2'd0;
    logic [31:0] in_data = 32'd0;
    logic [4:0]  in_shamt = 5'd0;
    logic        out_ready = 1'b1;

    logic [N-1:0] in_ready_v;
    logic [N-1:0] out_valid_v;
    logic [N-1:0] busy_v;
    logic [31:0]  out_data_v [N];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iter_shifter #(.XLEN(32), .STEP(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_type(in_type), .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_data(out_data_v[0]), .busy(busy_v[0])
    );
    iter_shifter #(.XLEN(32), .STEP(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_type(in_type), .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_data(out_data_v[1]), .busy(busy_v[1])
    );
    iter_shifter #(.XLEN(32), .STEP(32)) u_s32 (
        .clk(clk), .rst_n(rst_n), .kill(kill), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_type(in_type), .in_data(in_data), .in_shamt(in_shamt), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_data(out_data_v[2]), .busy(busy_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] t, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [63:0] dd;
        dd = {d, d} >> sh;
        case (t)
            2'd0:    return d << sh;
            2'd1:    return d >> sh;
            2'd2:    return 32'($signed(d) >>> sh);
            default: return dd[31:0];
        endcase
    endfunction

    // Reference: an accepted op is just a one-shot result that appears after ceil(shamt/STEP)
    // working cycles and is held until taken; kill or reset forgets it.
    typedef enum {M_IDLE, M_WORK, M_DONE} mstate_t;
    mstate_t     m_st   [N] = '{M_IDLE, M_IDLE, M_IDLE};
    int          m_cnt  [N] = '{0, 0, 0};
    logic [31:0] m_data [N] = '{32'd0, 32'd0, 32'd0};

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                check($sformatf("s%0d reset out_valid", STEPS[i]), 32'(out_valid_v[i]), 32'd0);
                check($sformatf("s%0d reset busy", STEPS[i]), 32'(busy_v[i]), 32'd0);
                check($sformatf("s%0d reset out_data", STEPS[i]), out_data_v[i], 32'd0);
                m_st[i] = M_IDLE;
            end else begin
                check($sformatf("s%0d in_ready", STEPS[i]), 32'(in_ready_v[i]),
                      32'(m_st[i] == M_IDLE && !kill));
                check($sformatf("s%0d out_valid", STEPS[i]), 32'(out_valid_v[i]),
                      32'(m_st[i] == M_DONE));
                check($sformatf("s%0d busy", STEPS[i]), 32'(busy_v[i]), 32'(m_st[i] != M_IDLE));
                if (m_st[i] == M_DONE)
                    check($sformatf("s%0d out_data", STEPS[i]), out_data_v[i], m_data[i]);

                if (kill) begin
                    m_st[i] = M_IDLE;
                end else if (m_st[i] == M_IDLE) begin
                    if (in_valid) begin
                        m_data[i] = ref_shift(in_type, in_data, in_shamt);
                        m_cnt[i]  = (int'(in_shamt) + STEPS[i] - 1) / STEPS[i];
                        m_st[i]   = (m_cnt[i] == 0) ? M_DONE : M_WORK;
                    end
                end else if (m_st[i] == M_WORK) begin
                    m_cnt[i]--;
                    if (m_cnt[i] == 0) m_st[i] = M_DONE;
                end else if (out_ready) begin
                    m_st[i] = M_IDLE;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_v != '0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " drain"}, 32'(busy_v), 32'd0);
    endtask

    // Literal expectation for the STEP=4 instance: result and accept-to-valid latency.
    task automatic run_op(input string name, input logic [1:0] t, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] exp, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_type   = t;
        in_data   = d;
        in_shamt  = sh;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_v[1] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " data"}, out_data_v[1], exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        wait_idle(name);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("sll 1<<31",      2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9);
        run_op("sra 8..0>>>31",  2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
        run_op("sra 4..0>>>30",  2'd2, 32'h4000_0000, 5'd30, 32'h0000_0001, 9);
        run_op("srl 2>>1",       2'd1, 32'h0000_0002, 5'd1,  32'h0000_0001, 2);
        for (int t = 0; t < 4; t++)
            run_op($sformatf("type%0d sh0", t), 2'(t), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
        run_op("ror 1 by 4",     2'd3, 32'h0000_0001, 5'd4,  32'h1000_0000, 2);
        run_op("ror 8..1 by 31", 2'd3, 32'h8000_0001, 5'd31, 32'h0000_0003, 9);
        run_op("sra pos step",   2'd2, 32'h7654_3210, 5'd7,  32'h00EC_A864, 3);

        // Back-pressure: result held in DONE, and a request there is ignored.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_type   = 2'd0;
        in_data   = 32'h0000_1234;
        in_shamt  = 5'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            check("hold data", out_data_v[1], 32'h0002_4680);
            check("hold in_ready", 32'(in_ready_v[1]), 32'd0);
            check("hold busy", 32'(busy_v[1]), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("done ignores request", out_data_v[1], 32'h0002_4680);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release in_ready", 32'(in_ready_v[1]), 32'd1);
        wait_idle("backpressure");

        // Kill in the third BUSY cycle.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_type  = 2'd0;
        in_data  = 32'h0000_000F;
        in_shamt = 5'd31;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill out_valid", 32'(out_valid_v[1]), 32'd0);
        check("kill busy", 32'(busy_v), 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // Kill beats a same-cycle request.
        in_valid = 1'b1;
        kill     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill beats accept", 32'(busy_v), 32'd0);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_type  = 2'd2;
        in_data  = 32'h8765_4321;
        in_shamt = 5'd29;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(out_valid_v), 32'd0);
        check("async rst busy", 32'(busy_v), 32'd0);
        check("async rst data s4", out_data_v[1], 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Random sweep with back-pressure and occasional kills.
        for (int n = 0; n < 200; n++) begin
            int cyc;
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_type   = 2'($urandom);
            in_data   = $urandom;
            in_shamt  = (n % 8 == 0) ? 5'd31 : (n % 8 == 1) ? 5'd0 : 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            kill      = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
            in_valid = 1'b0;
            kill     = 1'b0;
            cyc      = 0;
            while (busy_v != '0 && cyc < 300) begin
                out_ready = ($urandom_range(0, 3) != 0);
                kill      = ($urandom_range(0, 59) == 0);
                @(posedge clk); #1;
                cyc++;
            end
            kill = 1'b0;
            check("random drain", 32'(busy_v), 32'd0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
